debouncer: RTL and testbench

DEBOUNCER -- requirements
Module: debouncer

---
 rtl/debouncer.sv | 152 +++++++++++++++
 tb/tb_debouncer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
// Multi-channel input debouncer.
// Each raw input passes through a two-flop synchroniser. A shared prescaler
// produces a sample tick once every 2^DIV_W enabled cycles. A channel's
// debounced output flips only after STABLE consecutive ticks in which the
// synchronised input disagrees with the current output. A tick on which the
// input agrees with the output clears the channel's count.
// Optional macro DEBOUNCER_EDGE_EN: when defined, registered one-cycle
// rise/fall pulses are produced. When undefined, rise/fall are tied to 0
// and no edge registers exist.
module debouncer #(
  parameter int unsigned CH     = 4,     // number of channels, 1..32
  parameter int unsigned DIV_W  = 11,    // prescaler width, 1..16
  parameter int unsigned STABLE = 3,     // disagreeing ticks to flip, 1..15
  parameter logic        INIT   = 1'b0   // reset level of sync stages and out
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  // Terminal count value for the per-channel counter.
  // With STABLE=1 this is 0, so the first disagreeing tick flips the output.
  localparam logic [3:0] LAST = 4'(STABLE - 1);

  // ------------------------------------------------------------------
  // Shared prescaler
  // ------------------------------------------------------------------
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_d;
  logic             tick;

  // tick is qualified by en, so holding en low freezes the prescaler and
  // suppresses every tick.
  assign tick = en & (&presc_q);

  // Prescaler next state: count while enabled, wrapping naturally.
  always_comb begin
    presc_d = presc_q;
    if (en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ------------------------------------------------------------------
  // Two-flop synchroniser; only the second stage (s_q) is ever sampled
  // ------------------------------------------------------------------
  logic [CH-1:0] meta_q;
  logic [CH-1:0] s_q;

  // Synchroniser chain for all channels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= {CH{INIT}};
      s_q    <= {CH{INIT}};
    end else begin
      meta_q <= in;
      s_q    <= meta_q;
    end
  end

  // ------------------------------------------------------------------
  // Per-channel stability counters
  // ------------------------------------------------------------------
  logic [CH-1:0] out_q;
  logic [CH-1:0] out_d;

  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    logic [3:0] c_q;
    logic [3:0] c_d;
    logic       flip_d;

    // Count consecutive disagreeing ticks.
    // Any agreeing tick restarts the run, which makes short glitches invisible.
    always_comb begin
      c_d    = c_q;
      flip_d = out_q[gi];
      if (tick) begin
        if (s_q[gi] == out_q[gi]) begin
          c_d = '0;
        end else if (c_q == LAST) begin
          flip_d = s_q[gi];
          c_d    = '0;
        end else begin
          c_d = c_q + 4'd1;
        end
      end
    end

    // Counter register; reset discards any partial count.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        c_q <= '0;
      end else begin
        c_q <= c_d;
      end
    end

    assign out_d[gi] = flip_d;
  end

  // Debounced output register, shared by all channels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q <= {CH{INIT}};
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

  // ------------------------------------------------------------------
  // Edge pulses
  // ------------------------------------------------------------------
`ifdef DEBOUNCER_EDGE_EN
  logic [CH-1:0] rise_q;
  logic [CH-1:0] fall_q;

  // Pulses are computed from the same next-state value that loads out_q.
  // They therefore appear in the same cycle as the new out level.
  // Reset forces out_q and the pulses together, so reset never produces an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Scoreboard bench for debouncer.
// dut0: CH=2 DIV_W=2 STABLE=3 INIT=0 (main checks)
// dut1: same but INIT=1
// dut2: CH=1 DIV_W=1 STABLE=1
// Expected per-cycle outputs are queued when a scenario's stimulus starts.
// They are popped and compared on the falling edge after each rising edge.
module tb_debouncer;

`ifdef DEBOUNCER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b1;
  logic [1:0] in0 = 2'b00, out0, rise0, fall0;
  logic [1:0] in1 = 2'b00, out1, rise1, fall1;
  logic [0:0] in2 = 1'b0,  out2, rise2, fall2;

  always #5 clk = ~clk;

  debouncer #(.CH(2), .DIV_W(2), .STABLE(3), .INIT(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .en(en), .in(in0),
    .out(out0), .rise(rise0), .fall(fall0)
  );

  debouncer #(.CH(2), .DIV_W(2), .STABLE(3), .INIT(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .en(en), .in(in1),
    .out(out1), .rise(rise1), .fall(fall1)
  );

  debouncer #(.CH(1), .DIV_W(1), .STABLE(1), .INIT(1'b0)) dut2 (
    .clk(clk), .rstn(rstn), .en(en), .in(in2),
    .out(out2), .rise(rise2), .fall(fall2)
  );

  typedef struct {
    int         cyc;
    int         sel;
    logic [1:0] o;
    logic [1:0] r;
    logic [1:0] f;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  string sname   = "init";

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] pe(input logic [1:0] v);
    return EDGE ? v : 2'b00;
  endfunction

  task automatic push(input int c, input int s, input logic [1:0] o,
                      input logic [1:0] r, input logic [1:0] f);
    exp_t e;
    e.cyc = c; e.sel = s; e.o = o; e.r = r; e.f = f;
    sb.push_back(e);
  endtask

  // One clock: advance on the rising edge, then compare due entries on the falling edge.
  task automatic step();
    exp_t       e;
    logic [1:0] ao, ar, af;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        0: begin ao = out0; ar = rise0; af = fall0; end
        1: begin ao = out1; ar = rise1; af = fall1; end
        default: begin ao = {1'b0, out2}; ar = {1'b0, rise2}; af = {1'b0, fall2}; end
      endcase
      check($sformatf("%s c%0d d%0d out",  sname, e.cyc, e.sel), {30'd0, ao}, {30'd0, e.o});
      check($sformatf("%s c%0d d%0d rise", sname, e.cyc, e.sel), {30'd0, ar}, {30'd0, e.r});
      check($sformatf("%s c%0d d%0d fall", sname, e.cyc, e.sel), {30'd0, af}, {30'd0, e.f});
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    check({sname, " drain"}, sb.size(), 0);
    sb.delete();
    $display("[TB] scenario %s done at cycle %0d", sname, cyc);
  endtask

  // Assert reset between edges, check the forced values before any clock edge,
  // hold through one edge, and release mid-cycle.
  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check({sname, " rst out0"},  {30'd0, out0},  32'd0);
    check({sname, " rst rise0"}, {30'd0, rise0}, 32'd0);
    check({sname, " rst fall0"}, {30'd0, fall0}, 32'd0);
    check({sname, " rst out1"},  {30'd0, out1},  32'd3);
    check({sname, " rst rf1"},   {28'd0, rise1, fall1}, 32'd0);
    check({sname, " rst out2"},  {31'd0, out2},  32'd0);
    @(posedge clk);
    @(negedge clk);
    check({sname, " rst hold out1"}, {30'd0, out1}, 32'd3);
    #2 rstn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // A: in0=01 from release (dut0), INIT=1 with in=00 (dut1), STABLE=1 (dut2).
    sname = "A";
    en = 1'b1; in0 = 2'b01; in1 = 2'b00; in2 = 1'b1;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      push(c, 0, (c >= 12) ? 2'b01 : 2'b00, pe((c == 12) ? 2'b01 : 2'b00), 2'b00);
      push(c, 1, (c >= 12) ? 2'b00 : 2'b11, 2'b00, pe((c == 12) ? 2'b11 : 2'b00));
      push(c, 2, (c >= 4) ? 2'b01 : 2'b00, pe((c == 4) ? 2'b01 : 2'b00), 2'b00);
    end
    run(20);
    drain();

    // B: in0[1] seen high by exactly two ticks, then low, then held high.
    sname = "B";
    in0 = 2'b00; in2 = 1'b0;
    do_reset();
    for (int c = 1; c <= 26; c++)
      push(c, 0, (c >= 24) ? 2'b10 : 2'b00, pe((c == 24) ? 2'b10 : 2'b00), 2'b00);
    run(1);
    in0 = 2'b10;
    run(6);
    in0 = 2'b00;
    run(6);
    in0 = 2'b10;
    run(13);
    drain();

    // C: settle out=11, then in=00 with en low for 100 cycles, then en high.
    sname = "C";
    in0 = 2'b11;
    do_reset();
    for (int c = 1; c <= 126; c++)
      push(c, 0, (c >= 12 && c < 124) ? 2'b11 : 2'b00,
           pe((c == 12) ? 2'b11 : 2'b00), pe((c == 124) ? 2'b11 : 2'b00));
    run(12);
    en = 1'b0; in0 = 2'b00;
    run(100);
    en = 1'b1;
    run(14);
    drain();

    // D: two ticks of in0[0]=1, then a reset pulse; three fresh ticks are needed.
    sname = "D";
    in0 = 2'b01;
    do_reset();
    for (int c = 1; c <= 9; c++) push(c, 0, 2'b00, 2'b00, 2'b00);
    run(9);
    drain();
    sname = "D2";
    do_reset();
    for (int c = 1; c <= 14; c++)
      push(c, 0, (c >= 12) ? 2'b01 : 2'b00, pe((c == 12) ? 2'b01 : 2'b00), 2'b00);
    run(14);
    drain();

    // F: en dropped mid-count holds both the count and the prescaler.
    sname = "F";
    in0 = 2'b01;
    do_reset();
    for (int c = 1; c <= 34; c++)
      push(c, 0, (c >= 32) ? 2'b01 : 2'b00, pe((c == 32) ? 2'b01 : 2'b00), 2'b00);
    run(9);
    en = 1'b0;
    run(20);
    en = 1'b1;
    run(5);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
